fetch_prefetch_unit: RTL and testbench

Instruction-fetch front end that sits directly upstream of the decode stage. It keeps the fetch PC, talks to instruction memory over a variable-latency req/ack handshake, and buffers fetched words in a small prefetch queue. It drives the decode pipeline register (instructionD, pcplus4D) under the hazard unit's stall controls and branch redirects.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/prefetch_fifo.sv | 49 ++++
 rtl/fetch_prefetch_unit.sv | 129 ++++++++++++
 tb/tb_fetch_prefetch_unit.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
    localparam logic [31:0] WORD_BYTES = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Prefetch queue: DEPTH-entry synchronous FIFO, head visible combinationally, push lands next cycle.
// Clear beats push and pop; push when full and pop when empty are ignored.
module prefetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int PW    = clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  fetch_entry_t  push_dat_i,
    input  logic          pop_i,
    input  logic          clear_i,
    output fetch_entry_t  head_dat_o,
    output logic [PW:0]   count_o,
    output logic          full_o,
    output logic          empty_o
);

    fetch_entry_t        mem_q [DEPTH];
    logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [PW:0]         count_q;
    logic                do_push, do_pop;

    assign full_o     = (count_q == (PW+1)'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign head_dat_o = mem_q[rd_ptr_q];
    assign do_push    = push_i & ~full_o & ~clear_i;
    assign do_pop     = pop_i & ~empty_o & ~clear_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Fetch PC + single-outstanding imem handshake feeding a prefetch queue and the decode register (queue-to-D one edge).
// Decode stall freezes D; optional FETCH_PERF_EN adds saturating bubble/redirect counters.
module fetch_prefetch_unit
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        staIF,
    input  logic        StaID,
    input  logic        PCsrcD,
    input  logic [31:0] pcBranchD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instructionD,
    output logic [31:0] pcplus4D,
    output logic        validD
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] bubble_cnt,
    output logic [31:0] redirect_cnt
`endif
);

    localparam int          PW      = clog2(DEPTH);
    localparam logic [PW:0] DEPTH_L = (PW+1)'(DEPTH);

    logic [31:0]  fetch_pc_q, fetch_pc_d, req_addr_q;
    logic         pending_q, pending_d, drop_q, drop_d;
    logic [31:0]  instr_q, instr_d, pcp4_q, pcp4_d;
    logic         valid_q, valid_d;
    logic         issue_ok, ack_vld, redirect, accept, pop;
    fetch_entry_t head_dat, push_dat;
    logic [PW:0]  fifo_count;
    logic         fifo_full, fifo_empty;

    prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i      (CLK),
        .rst_ni     (reset),
        .push_i     (accept & ~fifo_full),
        .push_dat_i (push_dat),
        .pop_i      (pop),
        .clear_i    (redirect),
        .head_dat_o (head_dat),
        .count_o    (fifo_count),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    always_comb begin
        issue_ok = ~staIF & ~pending_q & ((fifo_count + {{PW{1'b0}}, pending_q}) < DEPTH_L);
        imem_req = reset & (pending_q | issue_ok);
        // An outstanding request keeps its own address even after a redirect moves fetch_pc.
        imem_addr = pending_q ? req_addr_q : fetch_pc_q;
        ack_vld   = imem_ack & imem_req;
        redirect  = PCsrcD & ~StaID;
        accept    = ack_vld & ~drop_q & ~redirect;
        pop       = ~StaID & ~fifo_empty & ~redirect;
        push_dat  = '{pc: imem_addr, instr: imem_rdata};
        pending_d = imem_req & ~ack_vld;

        drop_d = drop_q;
        if (redirect)     drop_d = imem_req & ~ack_vld;
        else if (ack_vld) drop_d = 1'b0;

        fetch_pc_d = fetch_pc_q;
        if (redirect)    fetch_pc_d = {pcBranchD[31:2], 2'b00};
        else if (accept) fetch_pc_d = fetch_pc_q + WORD_BYTES;

        instr_d = instr_q;
        pcp4_d  = pcp4_q;
        valid_d = valid_q;
        if (redirect || (!StaID && fifo_empty)) begin
            instr_d = NOP_INSTR;
            pcp4_d  = '0;
            valid_d = 1'b0;
        end else if (!StaID) begin
            instr_d = head_dat.instr;
            pcp4_d  = head_dat.pc + WORD_BYTES;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
            pending_q  <= 1'b0;
            drop_q     <= 1'b0;
            instr_q    <= NOP_INSTR;
            pcp4_q     <= '0;
            valid_q    <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= imem_addr;
            pending_q  <= pending_d;
            drop_q     <= drop_d;
            instr_q    <= instr_d;
            pcp4_q     <= pcp4_d;
            valid_q    <= valid_d;
        end
    end

    assign instructionD = instr_q;
    assign pcplus4D     = pcp4_q;
    assign validD       = valid_q;

`ifdef FETCH_PERF_EN
    logic [31:0] bubble_cnt_q, redirect_cnt_q;

    always_ff @(posedge CLK) begin
        if (!reset) begin
            bubble_cnt_q   <= '0;
            redirect_cnt_q <= '0;
        end else begin
            if (!StaID && fifo_empty && bubble_cnt_q != '1) bubble_cnt_q <= bubble_cnt_q + 32'd1;
            if (redirect && redirect_cnt_q != '1) redirect_cnt_q <= redirect_cnt_q + 32'd1;
        end
    end

    assign bubble_cnt   = bubble_cnt_q;
    assign redirect_cnt = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Bench for fetch_prefetch_unit: queue-based reference model plus a latency-configurable memory responder.
module tb_fetch_prefetch_unit;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        CLK = 1'b0;
    logic        reset, staIF, StaID, PCsrcD;
    logic [31:0] pcBranchD;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instructionD, pcplus4D;
    logic        validD;
`ifdef FETCH_PERF_EN
    logic [31:0] bubble_cnt, redirect_cnt;
`endif

    always #5 CLK = ~CLK;

    fetch_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .CLK          (CLK),
        .reset        (reset),
        .staIF        (staIF),
        .StaID        (StaID),
        .PCsrcD       (PCsrcD),
        .pcBranchD    (pcBranchD),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instructionD (instructionD),
        .pcplus4D     (pcplus4D),
        .validD       (validD)
`ifdef FETCH_PERF_EN
        ,
        .bubble_cnt   (bubble_cnt),
        .redirect_cnt (redirect_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [31:0] m_pc, m_paddr, m_instr, m_pcp4, m_bub, m_red;
    bit          m_pend, m_drop, m_valid;
    logic [31:0] q_pc[$];
    logic [31:0] q_in[$];

    // Memory responder state
    bit mem_busy;
    int mem_cnt;
    int maxlat;
    bit fixlat;

    // Outputs observed at the start of the most recent cycle
    logic        obs_req, obs_valid;
    logic [31:0] obs_addr, obs_instr, obs_pcp4;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = RPC; m_paddr = RPC; m_pend = 0; m_drop = 0;
        q_pc.delete(); q_in.delete();
        m_instr = 0; m_pcp4 = 0; m_valid = 0; m_bub = 0; m_red = 0;
    endtask

    task automatic cycle(input bit rst, input bit sif, input bit sid, input bit pcs, input logic [31:0] tgt);
        bit          e_req, ackv, redir;
        logic [31:0] e_addr;
        @(negedge CLK);
        reset = rst; staIF = sif; StaID = sid; PCsrcD = pcs; pcBranchD = tgt;
        imem_ack = 1'b0; imem_rdata = '0;
        #1;
        e_req  = rst && (m_pend || (!sif && q_pc.size() < DEPTH));
        e_addr = m_pend ? m_paddr : m_pc;
        obs_req = imem_req; obs_addr = imem_addr;
        obs_valid = validD; obs_instr = instructionD; obs_pcp4 = pcplus4D;
        chk("imem_req", imem_req, e_req);
        if (e_req) chk("imem_addr", imem_addr, e_addr);
        chk("validD", validD, m_valid);
        chk("instructionD", instructionD, m_instr);
        chk("pcplus4D", pcplus4D, m_pcp4);
`ifdef FETCH_PERF_EN
        chk("bubble_cnt", bubble_cnt, m_bub);
        chk("redirect_cnt", redirect_cnt, m_red);
`endif
        if (rst && imem_req && !mem_busy) begin
            mem_busy = 1;
            mem_cnt  = fixlat ? maxlat : int'($urandom_range(maxlat, 0));
        end
        if (rst && imem_req && mem_cnt == 0) begin
            imem_ack   = 1'b1;
            imem_rdata = imem_addr;
        end
        @(posedge CLK);
        if (!rst) begin
            model_reset();
        end else begin
            ackv  = imem_ack && e_req;
            redir = pcs && !sid;
            if (!sid && q_pc.size() == 0 && m_bub != 32'hFFFF_FFFF) m_bub++;
            if (redir) begin
                q_pc.delete(); q_in.delete();
                m_instr = 0; m_pcp4 = 0; m_valid = 0;
                if (m_red != 32'hFFFF_FFFF) m_red++;
            end else if (!sid) begin
                if (q_pc.size() > 0) begin
                    m_instr = q_in.pop_front();
                    m_pcp4  = q_pc.pop_front() + 32'd4;
                    m_valid = 1;
                end else begin
                    m_instr = 0; m_pcp4 = 0; m_valid = 0;
                end
            end
            if (ackv && !m_drop && !redir) begin
                q_pc.push_back(e_addr);
                q_in.push_back(imem_rdata);
                m_pc = m_pc + 32'd4;
            end
            if (redir)     m_drop = e_req && !ackv;
            else if (ackv) m_drop = 0;
            if (redir) m_pc = {tgt[31:2], 2'b00};
            m_pend  = e_req && !ackv;
            m_paddr = e_addr;
        end
        if (!rst || imem_ack) mem_busy = 0;
        else if (mem_busy && mem_cnt > 0) mem_cnt--;
    endtask

    initial begin
        logic [31:0] first_instr;
        bit          seen;
        bit          r_rst, r_sif, r_sid, r_pcs;
        logic [31:0] r_tgt;

        reset = 0; staIF = 0; StaID = 0; PCsrcD = 0; pcBranchD = 0;
        imem_ack = 0; imem_rdata = 0;
        mem_busy = 0; mem_cnt = 0; maxlat = 0; fixlat = 1;
        repeat (2) @(posedge CLK);
        model_reset();

        // Zero-wait memory: one word per cycle, first valid decode after two edges
        cycle(1, 0, 0, 0, 0);
        chk("first_req", obs_req, 1);
        chk("first_addr", obs_addr, 32'h0);
        chk("reset_validD", obs_valid, 0);
        chk("reset_instrD", obs_instr, 32'h0);
        cycle(1, 0, 0, 0, 0);
        chk("second_addr", obs_addr, 32'h4);
        chk("edge1_validD", obs_valid, 0);
        cycle(1, 0, 0, 0, 0);
        chk("edge2_validD", obs_valid, 1);
        chk("edge2_instrD", obs_instr, 32'h0);
        chk("edge2_pcplus4D", obs_pcp4, 32'h4);
        cycle(1, 0, 0, 0, 0);
        chk("edge3_instrD", obs_instr, 32'h4);
        chk("edge3_pcplus4D", obs_pcp4, 32'h8);

        // Decode stall fills the queue, then releases in order
        repeat (6) cycle(1, 0, 1, 0, 0);
        chk("stall_full_req", obs_req, 0);
        chk("stall_frozen_instrD", obs_instr, 32'h8);
        repeat (5) cycle(1, 0, 0, 0, 0);
        chk("release_instrD", obs_instr, 32'h18);

        // Redirect near the top of the address space wraps to zero
        cycle(1, 0, 0, 1, 32'hFFFF_FFFE);
        cycle(1, 0, 0, 0, 0);
        chk("wrap_addr0", obs_addr, 32'hFFFF_FFFC);
        chk("wrap_bubble", obs_valid, 0);
        cycle(1, 0, 0, 0, 0);
        chk("wrap_addr1", obs_addr, 32'h0);
        cycle(1, 0, 0, 0, 0);
        chk("wrap_instr0", obs_instr, 32'hFFFF_FFFC);
        chk("wrap_pcp4_0", obs_pcp4, 32'h0);
        cycle(1, 0, 0, 0, 0);
        chk("wrap_instr1", obs_instr, 32'h0);
        chk("wrap_pcp4_1", obs_pcp4, 32'h4);

        // Redirect while a request to 0x20 is still outstanding
        cycle(1, 0, 0, 1, 32'h20);
        maxlat = 2; fixlat = 1;
        cycle(1, 0, 0, 1, 32'h100);
        chk("drop_req_addr", obs_addr, 32'h20);
        cycle(1, 0, 0, 0, 0);
        chk("drop_addr_stable", obs_addr, 32'h20);
        seen = 0; first_instr = 32'hDEAD_BEEF;
        for (int i = 0; i < 12; i++) begin
            cycle(1, 0, 0, 0, 0);
            if (!seen && obs_valid) begin
                seen = 1;
                first_instr = obs_instr;
            end
        end
        chk("after_redirect_first", first_instr, 32'h100);

        // Reset pulsed while a request is waiting
        maxlat = 3; fixlat = 1;
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        chk("reset_req_low", obs_req, 0);
        cycle(1, 0, 0, 0, 0);
        chk("post_reset_valid", obs_valid, 0);
        chk("post_reset_req", obs_req, 1);
        chk("post_reset_addr", obs_addr, RPC);
`ifdef FETCH_PERF_EN
        chk("post_reset_bubble_cnt", bubble_cnt, 32'h0);
        chk("post_reset_redirect_cnt", redirect_cnt, 32'h0);
`endif

        // Randomized traffic at increasing memory latency
        for (int ph = 0; ph < 4; ph++) begin
            maxlat = ph; fixlat = 0;
            for (int n = 0; n < 1500; n++) begin
                r_rst = ($urandom_range(199, 0) != 0);
                r_sif = ($urandom_range(4, 0) == 0);
                r_sid = ($urandom_range(3, 0) == 0);
                r_pcs = ($urandom_range(11, 0) == 0);
                r_tgt = ($urandom_range(7, 0) == 0) ? (32'hFFFF_FFF8 | ($urandom() & 32'h7)) : $urandom();
                cycle(r_rst, r_sif, r_sid, r_pcs, r_tgt);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
